// File: rtl/r2sdf_bfly.sv
// Radix-2 single-path delay-feedback butterfly stage with saturating arithmetic.
// Define R2SDF_SCALE_EN for a round-half-up divide-by-2 on every butterfly result.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package r2sdf_pkg;
  localparam int DW = `DATA_WIDTH;

  typedef logic [2*DW-1:0] data_sample_t;

  function automatic logic [DW-1:0] addsub(
    input logic [DW-1:0] a,
    input logic [DW-1:0] b,
    input logic          sub
  );
    logic [DW:0] pre;
    pre = sub ? {a[DW-1], a} - {b[DW-1], b}
              : {a[DW-1], a} + {b[DW-1], b};
`ifdef R2SDF_SCALE_EN
    pre = pre + {{DW{1'b0}}, 1'b1};
    return pre[DW:1];
`else
    if (pre[DW] != pre[DW-1])
      return pre[DW] ? {1'b1, {(DW-1){1'b0}}}
                     : {1'b0, {(DW-1){1'b1}}};
    return pre[DW-1:0];
`endif
  endfunction

  function automatic data_sample_t cplx(
    input data_sample_t d,
    input data_sample_t x,
    input logic         sub
  );
    return {addsub(d[2*DW-1:DW], x[2*DW-1:DW], sub),
            addsub(d[DW-1:0], x[DW-1:0], sub)};
  endfunction
endpackage

module r2sdf_bfly
  import r2sdf_pkg::*;
#(
  parameter int DELAY = 8,
  parameter int CNT_W = $clog2(2*DELAY)
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  input  data_sample_t in_data,
  output logic         out_valid,
  output data_sample_t out_data,
  output logic         out_first
);

  typedef enum logic [1:0] {
    PRIME,
    BFLY,
    PASS
  } state_t;

  state_t       state;
  logic [CNT_W-1:0] cnt;
  data_sample_t dl [DELAY];
  data_sample_t head;
  data_sample_t sum;
  data_sample_t diff;
  data_sample_t push;
  logic         half_end;
  logic         frame_end;

  assign head      = dl[DELAY-1];
  assign sum       = cplx(head, in_data, 1'b0);
  assign diff      = cplx(head, in_data, 1'b1);
  assign push      = (state == BFLY) ? diff : in_data;
  assign half_end  = cnt == CNT_W'(DELAY-1);
  assign frame_end = cnt == CNT_W'(2*DELAY-1);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= PRIME;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      if (in_valid) begin
        cnt <= frame_end ? '0 : cnt + 1'b1;
        unique case (state)
          PRIME: begin
            if (half_end) state <= BFLY;
          end
          BFLY: begin
            out_valid <= 1'b1;
            out_first <= cnt == CNT_W'(DELAY);
            out_data  <= sum;
            if (frame_end) state <= PASS;
          end
          PASS: begin
            out_valid <= 1'b1;
            out_data  <= head;
            if (half_end) state <= BFLY;
          end
          default: state <= PRIME;
        endcase
      end
    end
  end

  // Head is read combinationally before the shift overwrites it.
  always_ff @(posedge clock) begin
    if (in_valid) begin
      dl[0] <= push;
      for (int i = 1; i < DELAY; i++)
        dl[i] <= dl[i-1];
    end
  end

endmodule

// File: tb/tb_r2sdf_bfly.sv
// Directed-vector bench for r2sdf_bfly at DELAY=1 and DELAY=2.
// Expected values are hand-computed; scaled set used when R2SDF_SCALE_EN is set.
module tb_r2sdf_bfly;
  import r2sdf_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         v1 = 1'b0;
  logic         v2 = 1'b0;
  data_sample_t in_data = '0;
  logic         ov1, of1, ov2, of2;
  data_sample_t od1, od2;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  r2sdf_bfly #(.DELAY(1)) dut1 (
    .clock(clk), .reset_n(reset_n),
    .in_valid(v1), .in_data(in_data),
    .out_valid(ov1), .out_data(od1), .out_first(of1)
  );

  r2sdf_bfly #(.DELAY(2)) dut2 (
    .clock(clk), .reset_n(reset_n),
    .in_valid(v2), .in_data(in_data),
    .out_valid(ov2), .out_data(od2), .out_first(of2)
  );

  typedef struct {
    string nm;
    bit    rst;
    bit    sel;
    bit    vld;
    int    xr;
    int    xi;
    bit    ev;
    int    er;
    int    ei;
    bit    ef;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string nm, bit rst, bit sel, bit vld,
                              int xr, int xi, bit ev, int er, int ei, bit ef);
    vec_t v;
    v.nm = nm; v.rst = rst; v.sel = sel; v.vld = vld;
    v.xr = xr; v.xi = xi; v.ev = ev; v.er = er; v.ei = ei; v.ef = ef;
    return v;
  endfunction

  task automatic apply(bit rst, bit sel, bit vld, int xr, int xi);
    @(negedge clk);
    reset_n = !rst;
    in_data = {xr[15:0], xi[15:0]};
    v1 = vld && !rst && !sel;
    v2 = vld && !rst && sel;
    @(posedge clk);
    #1;
  endtask

  task automatic check(string nm, bit sel, bit ev, int er, int ei,
                       bit ef, bit chk);
    logic ov, of;
    data_sample_t od, ex;
    ov = sel ? ov2 : ov1;
    of = sel ? of2 : of1;
    od = sel ? od2 : od1;
    ex = {er[15:0], ei[15:0]};
    nvec++;
    if (ov !== ev || of !== ef || (chk && od !== ex)) begin
      nmis++;
      $display("FAIL %s: got v=%0b f=%0b d=(%0d,%0d) want v=%0b f=%0b d=(%0d,%0d)",
               nm, ov, of, $signed(od[31:16]), $signed(od[15:0]),
               ev, ef, er, ei);
    end
  endtask

  int sx [6] = '{1, 2, 3, 4, 0, 0};
  bit sv [6] = '{0, 0, 1, 1, 1, 1};
  bit sf [6] = '{0, 0, 1, 0, 0, 0};
`ifdef R2SDF_SCALE_EN
  int se [6] = '{0, 0, 2, 3, -1, -1};
`else
  int se [6] = '{0, 0, 4, 6, -2, -2};
`endif

  initial begin
`ifdef R2SDF_SCALE_EN
    tbl.push_back(mk("rst_d1",   1, 0, 0,   0,  0, 0,  0,  0, 0));
    tbl.push_back(mk("t1_prime", 0, 0, 1, 100,  0, 0,  0,  0, 0));
    tbl.push_back(mk("t1_sum",   0, 0, 1,  20,  0, 1, 60,  0, 1));
    tbl.push_back(mk("t1_diff",  0, 0, 1,   0,  0, 1, 40,  0, 0));
    tbl.push_back(mk("rst_t6",   1, 0, 0,   0,  0, 0,  0,  0, 0));
    tbl.push_back(mk("t6_prime", 0, 0, 1, 100, -3, 0,  0,  0, 0));
    tbl.push_back(mk("t6_sum",   0, 0, 1,  21,  0, 1, 61, -1, 1));
    tbl.push_back(mk("t6_diff",  0, 0, 1,   0,  0, 1, 40, -1, 0));
`else
    tbl.push_back(mk("rst_d1",   1, 0, 0,      0,      0, 0,      0,      0, 0));
    tbl.push_back(mk("t1_prime", 0, 0, 1,    100,      0, 0,      0,      0, 0));
    tbl.push_back(mk("t1_sum",   0, 0, 1,     20,      0, 1,    120,      0, 1));
    tbl.push_back(mk("t1_diff",  0, 0, 1,      0,      0, 1,     80,      0, 0));
    tbl.push_back(mk("rst_t3",   1, 0, 0,      0,      0, 0,      0,      0, 0));
    tbl.push_back(mk("t3_prime", 0, 0, 1,  30000, -30000, 0,      0,      0, 0));
    tbl.push_back(mk("t3_sum",   0, 0, 1,  10000,  10000, 1,  32767, -20000, 1));
    tbl.push_back(mk("t3_diff",  0, 0, 1,      0,      0, 1,  20000, -32768, 0));
    tbl.push_back(mk("rst_neg",  1, 0, 0,      0,      0, 0,      0,      0, 0));
    tbl.push_back(mk("neg_prime",0, 0, 1,      0,    100, 0,      0,      0, 0));
    tbl.push_back(mk("neg_sum",  0, 0, 1, -32768, -32768, 1, -32768, -32668, 1));
    tbl.push_back(mk("neg_diff", 0, 0, 1,      0,      0, 1,  32767,  32767, 0));
`endif
    tbl.push_back(mk("rst_d2", 1, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk($sformatf("t2_%0d", i), 0, 1, 1, sx[i], sx[i],
                       sv[i], se[i], se[i], sf[i]));

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].sel, tbl[i].vld, tbl[i].xr, tbl[i].xi);
      check(tbl[i].nm, tbl[i].sel, tbl[i].ev, tbl[i].er, tbl[i].ei,
            tbl[i].ef, tbl[i].ev || tbl[i].rst);
    end

    // Stalls of 1..3 idle cycles between every sample.
    apply(1, 1, 0, 0, 0);
    check("rst_stall", 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      apply(0, 1, 1, sx[i], sx[i]);
      check($sformatf("stall_%0d", i), 1, sv[i], se[i], se[i], sf[i], sv[i]);
      for (int g = 0; g <= i % 3; g++) begin
        apply(0, 1, 0, 0, 0);
        check($sformatf("gap_%0d_%0d", i, g), 1, 0, 0, 0, 0, 0);
      end
    end

    // Reset in the middle of a frame discards the partial frame.
    apply(1, 1, 0, 0, 0);
    apply(0, 1, 1, 7, 7);
    apply(0, 1, 1, 9, 9);
    apply(0, 1, 1, 11, 11);
    apply(1, 1, 0, 0, 0);
    check("rst_mid", 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      apply(0, 1, 1, sx[i], sx[i]);
      check($sformatf("mid_%0d", i), 1, sv[i], se[i], se[i], sf[i], sv[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
